// File: rtl/intr_sched.sv
// Priority interrupt scheduler and vectoring sequencer with EOI retirement.
// Nested in-service support is enabled by defining INTR_SCHED_NEST_EN.
module intr_sched #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  output logic            cpu_intr,
  input  logic            cpu_ack,
  output logic [15:0]     cpu_vector,
  input  logic            io_write,
  input  logic [3:0]      io_addr,
  input  logic [15:0]     io_wdata,
  output logic [15:0]     io_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  // Bits of prio storage that belong to existing sources
  localparam logic [31:0] PMASK = (NSRC >= 16) ? 32'hFFFF_FFFF :
                                  32'((32'd1 << (2 * NSRC)) - 32'd1);

  state_t          r_state;
  logic [31:0]     r_prio;
  logic [NSRC-1:0] r_isr;
  logic [11:0]     r_base;
  logic [3:0]      r_idx;
  logic [1:0]      r_lprio;
  logic            r_intr;
  logic [15:0]     r_vec;

  logic [15:0]     w_irq16;
  logic            w_gate;
  logic [1:0]      w_cur;
  logic            w_el;
  logic            w_valid;
  logic [3:0]      w_best;
  logic [1:0]      w_bestp;
  logic            w_eoi_hit;
  logic [3:0]      w_eoi_idx;
  logic [1:0]      w_eoi_p;
  logic            w_eoi;
  logic            w_ack_ok;
  logic            w_spur;
  logic [NSRC-1:0] w_set;
  logic [NSRC-1:0] w_eoi_mask;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_isr_nxt;

  assign w_irq16 = 16'(irq_in);
`ifdef INTR_SCHED_NEST_EN
  assign w_gate = 1'b1;
`else
  assign w_gate = (r_isr == '0);
`endif

  always_comb begin
    w_cur     = 2'd0;
    w_el      = 1'b0;
    w_valid   = 1'b0;
    w_best    = 4'd0;
    w_bestp   = 2'd0;
    w_eoi_hit = 1'b0;
    w_eoi_idx = 4'd0;
    w_eoi_p   = 2'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (r_isr[i] && (r_prio[2*i +: 2] > w_cur))
        w_cur = r_prio[2*i +: 2];
      if (r_isr[i] && (!w_eoi_hit || (r_prio[2*i +: 2] > w_eoi_p))) begin
        w_eoi_hit = 1'b1;
        w_eoi_idx = 4'(i);
        w_eoi_p   = r_prio[2*i +: 2];
      end
    end
    // Strict > on ties keeps the lowest index
    for (int i = 0; i < NSRC; i++) begin
      w_el = irq_in[i] & ~r_isr[i] & w_gate &
             (r_prio[2*i +: 2] > w_cur);
      if (w_el && (!w_valid || (r_prio[2*i +: 2] > w_bestp))) begin
        w_valid = 1'b1;
        w_best  = 4'(i);
        w_bestp = r_prio[2*i +: 2];
      end
    end
  end

  assign w_eoi    = io_write && (io_addr == 4'd4);
  assign w_ack_ok = (r_state == S_REQ) && cpu_ack && w_irq16[r_idx];
  assign w_spur   = (r_state == S_REQ) && cpu_ack && !w_irq16[r_idx];
  assign w_clr    = (io_write && (io_addr == 4'd5)) ?
                    io_wdata[NSRC-1:0] : '0;

  always_comb begin
    w_set      = '0;
    w_eoi_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_set[i]      = w_ack_ok && (r_idx == 4'(i));
      w_eoi_mask[i] = w_eoi && w_eoi_hit && (w_eoi_idx == 4'(i));
    end
  end

  // EOI acts on the pre-cycle isr, then the ack bit lands
  assign w_isr_nxt = (r_isr & ~w_eoi_mask & ~w_clr) | w_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_prio  <= '0;
      r_isr   <= '0;
      r_base  <= '0;
      r_idx   <= '0;
      r_lprio <= '0;
      r_intr  <= 1'b0;
      r_vec   <= '0;
    end else begin
      r_isr <= w_isr_nxt;
      if (io_write) begin
        case (io_addr)
          4'd2: r_prio[15:0]  <= io_wdata & PMASK[15:0];
          4'd3: r_prio[31:16] <= io_wdata & PMASK[31:16];
          4'd6: r_base        <= io_wdata[15:4];
          default: ;
        endcase
      end
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_idx   <= w_best;
            r_lprio <= w_bestp;
            r_intr  <= 1'b1;
            r_vec   <= {r_base, w_best};
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!cpu_ack) begin
            if (w_valid && (w_bestp > r_lprio)) begin
              r_idx   <= w_best;
              r_lprio <= w_bestp;
              r_vec   <= {r_base, w_best};
            end else begin
              r_vec   <= {r_base, r_idx};
            end
          end else begin
            r_intr  <= 1'b0;
            r_vec   <= {r_base, w_spur ? 4'hF : r_idx};
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!cpu_ack)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_intr   = r_intr;
  assign cpu_vector = w_spur ? {r_vec[15:4], 4'hF} : r_vec;

  always_comb begin
    case (io_addr)
      4'd0:    io_rdata = 16'(r_isr);
      4'd1:    io_rdata = {w_valid, 11'h0, w_best};
      4'd2:    io_rdata = r_prio[15:0];
      4'd3:    io_rdata = r_prio[31:16];
      4'd6:    io_rdata = {r_base, 4'h0};
      default: io_rdata = 16'h0;
    endcase
  end

endmodule

// File: tb/tb_intr_sched.sv
// Scoreboard bench for intr_sched: stimulus queues expectations,
// a negedge monitor compares register reads, requests and ack vectors.
module tb_intr_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_in;
  logic        cpu_intr;
  logic        cpu_ack;
  logic [15:0] cpu_vector;
  logic        io_write;
  logic [3:0]  io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;

  intr_sched #(.NSRC(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .cpu_intr   (cpu_intr),
    .cpu_ack    (cpu_ack),
    .cpu_vector (cpu_vector),
    .io_write   (io_write),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } samp_t;

  typedef struct {
    logic [15:0] vec;
    int          due;
  } req_t;

  samp_t       q_s[$];
  req_t        q_vec[$];
  logic [15:0] q_ack[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        prev_intr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    samp_t       s;
    req_t        r;
    logic [15:0] act;
    logic [15:0] e;
    while (q_s.size() > 0) begin
      s = q_s.pop_front();
      case (s.kind)
        0:       act = io_rdata;
        1:       act = {15'h0, cpu_intr};
        default: act = cpu_vector;
      endcase
      checks++;
      if (act !== s.exp) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", s.name, act, s.exp);
      end
    end
    if (cpu_intr && !prev_intr) begin
      checks++;
      if (q_vec.size() == 0) begin
        failures++;
        $display("FAIL unexpected_req actual=%h required=none", cpu_vector);
      end else begin
        r = q_vec.pop_front();
        if (cpu_vector !== r.vec || cyc > r.due) begin
          failures++;
          $display("FAIL req_vector actual=%h@%0d required=%h@<=%0d",
                   cpu_vector, cyc, r.vec, r.due);
        end
      end
    end
    if (cpu_intr && cpu_ack) begin
      checks++;
      if (q_ack.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack actual=%h required=none", cpu_vector);
      end else begin
        e = q_ack.pop_front();
        if (cpu_vector !== e) begin
          failures++;
          $display("FAIL ack_vector actual=%h required=%h", cpu_vector, e);
        end
      end
    end
    prev_intr = cpu_intr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [15:0] exp,
                     input string name);
    samp_t s;
    s.kind = kind;
    s.exp  = exp;
    s.name = name;
    q_s.push_back(s);
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp,
                    input string name);
    io_addr = a;
    chk(0, exp, name);
    tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    io_write = 1'b1;
    io_addr  = a;
    io_wdata = d;
    tick();
    io_write = 1'b0;
  endtask

  task automatic expect_req(input logic [15:0] v, input int lat);
    req_t r;
    r.vec = v;
    r.due = cyc + lat;
    q_vec.push_back(r);
  endtask

  task automatic wait_intr(input string name);
    for (int k = 0; k < 20 && !cpu_intr; k++) tick();
    if (!cpu_intr) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=0 required=1", name);
    end
  endtask

  task automatic ack(input logic [15:0] v, input string name);
    wait_intr(name);
    q_ack.push_back(v);
    cpu_ack = 1'b1;
    tick();
    chk(1, 16'h0, {name, "_intr_low"});
    chk(2, v, {name, "_vec_hold"});
    tick();
    cpu_ack = 1'b0;
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    irq_in   = '0;
    cpu_ack  = 1'b0;
    io_write = 1'b0;
    io_addr  = '0;
    io_wdata = '0;
    tick();
    tick();
    reset = 1'b0;

    chk(1, 16'h0, "rst_intr");
    chk(2, 16'h0, "rst_vec");
    rd(0, 16'h0, "rst_isr");
    rd(1, 16'h0, "rst_reg1");
    rd(2, 16'h0, "rst_prio");
    rd(6, 16'h0, "rst_base");

    // Basic request, ack, EOI
    wr(2, 16'h0020);
    wr(6, 16'h0100);
    rd(6, 16'h0100, "base_rd");
    expect_req(16'h0102, 1);
    irq_in = 6'h04;
    ack(16'h0102, "basic");
    rd(0, 16'h0004, "basic_isr");
    irq_in = 6'h00;
    wr(4, 16'h0);
    rd(0, 16'h0000, "basic_eoi");

    // Nesting
    wr(2, 16'h0301);
    expect_req(16'h0100, 1);
    irq_in = 6'h01;
    ack(16'h0100, "nest_a");
    rd(0, 16'h0001, "nest_isr1");
`ifdef INTR_SCHED_NEST_EN
    expect_req(16'h0104, 1);
    irq_in = 6'h11;
    ack(16'h0104, "nest_b");
    rd(0, 16'h0011, "nest_isr2");
    irq_in = 6'h01;
    wr(4, 16'h0);
    rd(0, 16'h0001, "nest_eoi1");
    irq_in = 6'h00;
    wr(4, 16'h0);
    rd(0, 16'h0000, "nest_eoi2");
`else
    irq_in = 6'h11;
    tick();
    tick();
    rd(1, 16'h0000, "nonest_blocked");
    irq_in = 6'h10;
    expect_req(16'h0104, 2);
    wr(4, 16'h0);
    ack(16'h0104, "nonest_b");
    rd(0, 16'h0010, "nonest_isr");
    irq_in = 6'h00;
    wr(4, 16'h0);
    rd(0, 16'h0000, "nonest_eoi");
`endif

    // Tie and replacement
    wr(2, 16'h0C88);
    rd(2, 16'h0C88, "prio_rd");
    expect_req(16'h0101, 1);
    irq_in = 6'h0A;
    wait_intr("tie");
    irq_in = 6'h2A;
    tick();
    ack(16'h0105, "replace");
    rd(0, 16'h0020, "replace_isr");
    rd(1, 16'h0000, "lower_masked");
    irq_in = 6'h00;
    wr(4, 16'h0);
    rd(0, 16'h0000, "replace_eoi");

    // Spurious
    expect_req(16'h0101, 1);
    irq_in = 6'h02;
    wait_intr("spur");
    irq_in = 6'h00;
    tick();
    ack(16'h010F, "spur");
    rd(0, 16'h0000, "spur_isr");

    // Masking
    irq_in = 6'h01;
    tick();
    tick();
    rd(1, 16'h0000, "prio0_valid");
    wr(2, 16'h0CB8);
    expect_req(16'h0105, 1);
    irq_in = 6'h20;
    ack(16'h0105, "lvl_a");
    rd(0, 16'h0020, "lvl_isr");
    irq_in = 6'h24;
    tick();
    tick();
    rd(1, 16'h0000, "equal_lvl");
    irq_in = 6'h04;
    expect_req(16'h0102, 2);
    wr(4, 16'h0);
    ack(16'h0102, "lvl_b");
    rd(0, 16'h0004, "lvl_isr2");
    irq_in = 6'h00;
    wr(5, 16'h0004);
    rd(0, 16'h0000, "clr5");

    // Ack and EOI in the same cycle
`ifdef INTR_SCHED_NEST_EN
    wr(2, 16'h0830);
    expect_req(16'h0105, 1);
    irq_in = 6'h20;
    ack(16'h0105, "same_a");
    expect_req(16'h0102, 1);
    irq_in = 6'h24;
    wait_intr("same_b");
    wr(2, 16'h0C10);
`else
    wr(2, 16'h0C10);
    expect_req(16'h0102, 1);
    irq_in = 6'h04;
    wait_intr("same_b");
`endif
    q_ack.push_back(16'h0102);
    cpu_ack  = 1'b1;
    io_write = 1'b1;
    io_addr  = 4'd4;
    io_wdata = 16'h0;
    tick();
    io_write = 1'b0;
    irq_in   = 6'h00;
    chk(1, 16'h0, "same_intr_low");
    rd(0, 16'h0004, "same_isr");

    // Reset in WAIT with ack held
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk(1, 16'h0, "wrst_intr");
    rd(0, 16'h0000, "wrst_isr");
    rd(2, 16'h0000, "wrst_prio");
    rd(6, 16'h0000, "wrst_base");
    wr(2, 16'h0020);
    cpu_ack = 1'b0;
    expect_req(16'h0002, 1);
    irq_in = 6'h04;
    ack(16'h0002, "wrst_req");
    irq_in = 6'h00;
    wr(4, 16'h0);
    rd(0, 16'h0000, "wrst_eoi");

    tick();
    tick();
    checks++;
    if (q_s.size() + q_vec.size() + q_ack.size() != 0) begin
      failures++;
      $display("FAIL leftover actual=%0d required=0",
               q_s.size() + q_vec.size() + q_ack.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
